// File: rtl/serial_parity_rx_if.sv
// Bus bundle for serial_parity_rx: serial input stream and valid/ready word output.
// master: frame source / word consumer. slave: the receiver itself.
interface serial_parity_rx_if #(
    parameter int unsigned DATA_W = 8
) ();

    logic              sin_valid;
    logic              sin_bit;
    logic              sin_sof;
    logic [DATA_W-1:0] out_data;
    logic              out_parity_err;
    logic              out_valid;
    logic              out_ready;
    logic              overrun;

    modport master (
        output sin_valid,
        output sin_bit,
        output sin_sof,
        output out_ready,
        input  out_data,
        input  out_parity_err,
        input  out_valid,
        input  overrun
    );

    modport slave (
        input  sin_valid,
        input  sin_bit,
        input  sin_sof,
        input  out_ready,
        output out_data,
        output out_parity_err,
        output out_valid,
        output overrun
    );

endinterface

// File: rtl/serial_parity_rx.sv
// Bit-serial frame receiver with XOR parity check.
// Takes DATA_W data bits LSB first after a sof-qualified bit 0, then one parity
// bit; the assembled word is offered on a registered valid/ready port.
// A frame that completes while the output holds an unaccepted word is dropped
// and reported with a one-cycle overrun pulse.
// Optional feature macro: SPRX_ERR_CNT_EN adds a saturating 16-bit count of
// parity-errored words loaded into the output register (err_count port).
module serial_parity_rx #(
    parameter int unsigned DATA_W = 8,
    parameter bit          ODD    = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    serial_parity_rx_if.slave  bus
`ifdef SPRX_ERR_CNT_EN
    ,
    output logic [15:0]        err_count
`endif
);

    localparam int unsigned CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int unsigned ERR_W    = 16;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DATA   = 2'd1;
    localparam logic [1:0] PARITY = 2'd2;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              rxor_q, rxor_d;

    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_parity_err_q, out_parity_err_d;
    logic              out_valid_q, out_valid_d;
    logic              overrun_q, overrun_d;

    logic              frame_done;
    logic              frame_err;
    logic              out_load;

    // Receive state, bit counter, shift register and running parity.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            rxor_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            rxor_q  <= rxor_d;
        end
    end

    // Frame assembly: a sof always restarts at bit 0, even mid-frame.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        rxor_d     = rxor_q;
        frame_done = 1'b0;
        frame_err  = 1'b0;

        if (bus.sin_valid) begin
            if (bus.sin_sof) begin
                state_d    = DATA;
                cnt_d      = CNT_W'(1);
                shift_d    = '0;
                shift_d[0] = bus.sin_bit;
                rxor_d     = bus.sin_bit;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_d = IDLE;
                    end
                    DATA: begin
                        for (int unsigned i = 0; i < DATA_W; i++) begin
                            if (cnt_q == CNT_W'(i)) begin
                                shift_d[i] = bus.sin_bit;
                            end
                        end
                        rxor_d = rxor_q ^ bus.sin_bit;
                        if (cnt_q == LAST_CNT) begin
                            state_d = PARITY;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    PARITY: begin
                        frame_done = 1'b1;
                        frame_err  = rxor_q ^ bus.sin_bit ^ ODD;
                        state_d    = IDLE;
                        cnt_d      = '0;
                        rxor_d     = 1'b0;
                    end
                    default: begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        rxor_d  = 1'b0;
                    end
                endcase
            end
        end
    end

    // Output holding register, decoupled from the shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_q       <= '0;
            out_parity_err_q <= 1'b0;
            out_valid_q      <= 1'b0;
            overrun_q        <= 1'b0;
        end else begin
            out_data_q       <= out_data_d;
            out_parity_err_q <= out_parity_err_d;
            out_valid_q      <= out_valid_d;
            overrun_q        <= overrun_d;
        end
    end

    // Load a completed frame when the slot is free or being drained, else drop it.
    always_comb begin
        out_data_d       = out_data_q;
        out_parity_err_d = out_parity_err_q;
        out_valid_d      = out_valid_q;
        out_load         = frame_done && (!out_valid_q || bus.out_ready);
        overrun_d        = frame_done && !out_load;

        if (out_load) begin
            out_data_d       = shift_q;
            out_parity_err_d = frame_err;
            out_valid_d      = 1'b1;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    assign bus.out_data       = out_data_q;
    assign bus.out_parity_err = out_parity_err_q;
    assign bus.out_valid      = out_valid_q;
    assign bus.overrun        = overrun_q;

`ifdef SPRX_ERR_CNT_EN
    logic [ERR_W-1:0] err_count_q, err_count_d;

    // Saturating count of errored words that actually reach the output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count_q <= '0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    // Increment only on a load with error; dropped frames are not counted.
    always_comb begin
        err_count_d = err_count_q;
        if (out_load && frame_err && (err_count_q != {ERR_W{1'b1}})) begin
            err_count_d = err_count_q + ERR_W'(1);
        end
    end

    assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_serial_parity_rx.sv
// Randomized self-checking bench for serial_parity_rx with a queue-based frame model.
// Build with +define+SPRX_ERR_CNT_EN to also check err_count.
module tb_serial_parity_rx;

    localparam int unsigned DW    = 8;
    localparam bit          ODD_P = 1'b0;

    logic clk = 1'b0;
    logic rst = 1'b1;

    serial_parity_rx_if #(.DATA_W(DW)) bus ();

`ifdef SPRX_ERR_CNT_EN
    logic [15:0] err_count;
`endif

    serial_parity_rx #(.DATA_W(DW), .ODD(ODD_P)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef SPRX_ERR_CNT_EN
        ,
        .err_count (err_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [DW-1:0] m_data;
    bit            m_err, m_valid, m_ovr;
    int            m_errcnt;
    int            m_loads;
    bit            in_frame;
    bit            fq[$];

    bit rdy     = 1'b0;
    bit rnd_rdy = 1'b0;
    int dut_ovr_pulses = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_data   = '0;
        m_err    = 1'b0;
        m_valid  = 1'b0;
        m_ovr    = 1'b0;
        m_errcnt = 0;
        in_frame = 1'b0;
        fq.delete();
    endtask

    // One clock edge of the model: collect bits since sof, emit a frame at DW+1 bits.
    task automatic model_edge(input bit v, input bit b, input bit s, input bit r);
        bit            done = 1'b0;
        bit            perr = ODD_P;
        bit            load;
        logic [DW-1:0] w = '0;
        if (v) begin
            if (s) begin
                fq.delete();
                fq.push_back(b);
                in_frame = 1'b1;
            end else if (in_frame) begin
                fq.push_back(b);
                if (fq.size() == DW + 1) begin
                    done = 1'b1;
                    for (int i = 0; i < int'(DW); i++) w[i] = fq[i];
                    for (int i = 0; i <= int'(DW); i++) perr ^= fq[i];
                    fq.delete();
                    in_frame = 1'b0;
                end
            end
        end
        load  = done && (!m_valid || r);
        m_ovr = done && !load;
        if (load) begin
            m_data  = w;
            m_err   = perr;
            m_valid = 1'b1;
            m_loads++;
            if (perr && m_errcnt < 65535) m_errcnt++;
        end else if (m_valid && r) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic step(input bit v, input bit b, input bit s);
        if (rnd_rdy) rdy = 1'($urandom_range(0, 1));
        bus.sin_valid = v;
        bus.sin_bit   = b;
        bus.sin_sof   = s;
        bus.out_ready = rdy;
        @(posedge clk);
        if (!rst) model_edge(v, b, s, rdy);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    task automatic send_frame(input logic [DW-1:0] word, input bit par, input int gapmax);
        for (int i = 0; i < int'(DW); i++) begin
            step(1'b1, word[i], i == 0);
            if (gapmax > 0) idle($urandom_range(0, gapmax));
        end
        step(1'b1, par, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #2;
        chk("rst_valid",   32'(bus.out_valid), 32'd0);
        chk("rst_data",    32'(bus.out_data), 32'd0);
        chk("rst_perr",    32'(bus.out_parity_err), 32'd0);
        chk("rst_overrun", 32'(bus.overrun), 32'd0);
`ifdef SPRX_ERR_CNT_EN
        chk("rst_errcnt",  32'(err_count), 32'd0);
`endif
        step(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    // Every-cycle comparison of all DUT outputs against the model.
    always @(negedge clk) begin
        chk("cyc_valid",   32'(bus.out_valid), 32'(m_valid));
        chk("cyc_data",    32'(bus.out_data), 32'(m_data));
        chk("cyc_perr",    32'(bus.out_parity_err), 32'(m_err));
        chk("cyc_overrun", 32'(bus.overrun), 32'(m_ovr));
`ifdef SPRX_ERR_CNT_EN
        chk("cyc_errcnt",  32'(err_count), 32'(m_errcnt));
`endif
        if (bus.overrun === 1'b1) dut_ovr_pulses++;
    end

    initial begin
        int base_loads;
        int base_ovr;
        model_reset();
        m_loads = 0;
        bus.sin_valid = 1'b0;
        bus.sin_bit   = 1'b0;
        bus.sin_sof   = 1'b0;
        bus.out_ready = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        do_reset();

        // 0xA5, correct even parity
        rdy = 1'b1;
        send_frame(8'hA5, 1'b0, 0);
        chk("t1_valid", 32'(bus.out_valid), 32'd1);
        chk("t1_data",  32'(bus.out_data), 32'hA5);
        chk("t1_perr",  32'(bus.out_parity_err), 32'd0);
        chk("t1_model", 32'(m_data), 32'hA5);
        step(1'b0, 1'b0, 1'b0);
        chk("t1_drop_valid", 32'(bus.out_valid), 32'd0);

        // 0xA5 with wrong parity bit
        send_frame(8'hA5, 1'b1, 0);
        chk("t2_data",  32'(bus.out_data), 32'hA5);
        chk("t2_perr",  32'(bus.out_parity_err), 32'd1);
        chk("t2_model_errcnt", 32'(m_errcnt), 32'd1);
`ifdef SPRX_ERR_CNT_EN
        chk("t2_errcnt", 32'(err_count), 32'd1);
`endif
        step(1'b0, 1'b0, 1'b0);

        // Stalled output: second frame overruns
        rdy = 1'b0;
        base_ovr = dut_ovr_pulses;
        send_frame(8'h3C, 1'b0, 0);
        send_frame(8'hC3, 1'b0, 0);
        chk("t3_overrun", 32'(bus.overrun), 32'd1);
        chk("t3_data",    32'(bus.out_data), 32'h3C);
        step(1'b0, 1'b0, 1'b0);
        chk("t3_overrun_end", 32'(bus.overrun), 32'd0);
        chk("t3_data_hold",   32'(bus.out_data), 32'h3C);
        chk("t3_pulses",      32'(dut_ovr_pulses - base_ovr), 32'd1);
        rdy = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        chk("t3_valid_drop", 32'(bus.out_valid), 32'd0);

        // Gaps of 1..3 idle cycles between bits
        base_loads = m_loads;
        for (int i = 0; i < int'(DW); i++) begin
            step(1'b1, 1'((8'h81 >> i) & 1), i == 0);
            idle($urandom_range(1, 3));
        end
        step(1'b1, 1'b0, 1'b0);
        chk("t4_data",  32'(bus.out_data), 32'h81);
        chk("t4_perr",  32'(bus.out_parity_err), 32'd0);
        chk("t4_loads", 32'(m_loads - base_loads), 32'd1);

        // Partial frame aborted by a new sof
        base_loads = m_loads;
        base_ovr   = dut_ovr_pulses;
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        send_frame(8'h0F, 1'b0, 0);
        chk("t5_data",   32'(bus.out_data), 32'h0F);
        chk("t5_perr",   32'(bus.out_parity_err), 32'd0);
        step(1'b0, 1'b0, 1'b0);
        chk("t5_loads",  32'(m_loads - base_loads), 32'd1);
        chk("t5_no_ovr", 32'(dut_ovr_pulses - base_ovr), 32'd0);

        // Reset mid-frame, then a clean frame
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, i == 0);
        do_reset();
        base_loads = m_loads;
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        send_frame(8'h55, 1'b0, 0);
        chk("t6_data",  32'(bus.out_data), 32'h55);
        chk("t6_valid", 32'(bus.out_valid), 32'd1);
        step(1'b0, 1'b0, 1'b0);
        chk("t6_loads", 32'(m_loads - base_loads), 32'd1);

        // Randomized traffic: well-formed frames, noise, resyncs, random ready
        rnd_rdy = 1'b1;
        for (int it = 0; it < 1200; it++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: send_frame(DW'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 2));
                5, 6: step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));
                7: idle($urandom_range(1, 4));
                8: for (int k = 0; k < int'($urandom_range(1, DW)); k++)
                       step(1'b1, 1'($urandom_range(0, 1)), k == 0);
                default: if ($urandom_range(0, 30) == 0) do_reset();
                         else step(1'b0, 1'b0, 1'b0);
            endcase
        end
        rnd_rdy = 1'b0;
        rdy = 1'b1;
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
